// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, instruction ROM request, and prefetch queue feeding ID.
// Optional performance counters are enabled with the IF_FETCH_PERF_EN macro.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] id_inst_o,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_flush_o
`else
  output logic [31:0] id_inst_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      r_pc;
  logic [31:0]      r_q_pc   [FIFO_DEPTH];
  logic [31:0]      r_q_inst [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_fetch;
  logic             w_valid;
  logic             w_pop;

  // Fetch only while the queue has room and no redirect is in flight.
  assign w_fetch = !rst && !branch_flag_i && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_valid = !rst && !branch_flag_i && (r_count != '0);
  assign w_pop   = w_valid && id_ready_i;

  assign rom_ce_o   = w_fetch;
  assign rom_addr_o = w_fetch ? r_pc : 32'h0;

  assign id_valid_o = w_valid;
  assign id_pc_o    = w_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
  assign id_inst_o  = w_valid ? r_q_inst[r_rd_ptr] : 32'h0;

  // Queue storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_inst[r_wr_ptr] <= rom_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (branch_flag_i) begin
      r_pc     <= branch_target_i & 32'hFFFF_FFFC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  // Flush counter only counts redirects that actually discard queued work.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= 32'h0;
      r_perf_flush <= 32'h0;
    end else begin
      if (w_fetch) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (branch_flag_i && (r_count != '0)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (two instances: RESET_PC 0 and FFFF_FFF8).
module tb_inst_fetch_unit;

  logic        clk;
  int          n_checks;
  int          n_fail;

  logic        rst_a, br_a, rdy_a;
  logic [31:0] tgt_a;
  logic        ce_a, vld_a;
  logic [31:0] addr_a, rinst_a, pc_a, inst_a;

  logic        rst_b, br_b, rdy_b;
  logic [31:0] tgt_b;
  logic        ce_b, vld_b;
  logic [31:0] addr_b, rinst_b, pc_b, inst_b;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] pf_a, pl_a;
  logic [31:0] unused_pf_b, unused_pl_b;
`endif

  assign rinst_a = addr_a ^ 32'hA5A5_0000;
  assign rinst_b = addr_b ^ 32'hA5A5_0000;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst_a), .rom_ce_o(ce_a), .rom_addr_o(addr_a), .rom_inst_i(rinst_a),
    .branch_flag_i(br_a), .branch_target_i(tgt_a), .id_ready_i(rdy_a),
    .id_valid_o(vld_a), .id_pc_o(pc_a),
`ifdef IF_FETCH_PERF_EN
    .id_inst_o(inst_a), .perf_fetch_o(pf_a), .perf_flush_o(pl_a)
`else
    .id_inst_o(inst_a)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst_b), .rom_ce_o(ce_b), .rom_addr_o(addr_b), .rom_inst_i(rinst_b),
    .branch_flag_i(br_b), .branch_target_i(tgt_b), .id_ready_i(rdy_b),
    .id_valid_o(vld_b), .id_pc_o(pc_b),
`ifdef IF_FETCH_PERF_EN
    .id_inst_o(inst_b), .perf_fetch_o(unused_pf_b), .perf_flush_o(unused_pl_b)
`else
    .id_inst_o(inst_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n_ce;
    logic [31:0] exp_b [4];
    n_checks = 0;
    n_fail   = 0;
    clk   = 1'b0;
    rst_a = 1'b1; br_a = 1'b0; rdy_a = 1'b1; tgt_a = 32'h0;
    rst_b = 1'b1; br_b = 1'b0; rdy_b = 1'b0; tgt_b = 32'h0;

    // Reset state
    cyc(); cyc();
    chk("rst_ce", 32'(ce_a), 32'h0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_vld", 32'(vld_a), 32'h0);
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_inst", inst_a, 32'h0);

    // Streaming at one instruction per cycle
    rst_a = 1'b0; #1;
    for (int k = 0; k < 6; k++) begin
      chk("str_ce", 32'(ce_a), 32'h1);
      chk("str_addr", addr_a, 32'(4 * k));
      if (k == 0) begin
        chk("str_vld0", 32'(vld_a), 32'h0);
      end else begin
        chk("str_vld", 32'(vld_a), 32'h1);
        chk("str_pc", pc_a, 32'(4 * (k - 1)));
        chk("str_inst", inst_a, 32'(4 * (k - 1)) ^ 32'hA5A5_0000);
      end
      cyc();
    end

    // Back-pressure: fill to full, then drain without a gap
    rst_a = 1'b1; cyc();
    rst_a = 1'b0; rdy_a = 1'b0; #1;
    n_ce = 0;
    for (int i = 0; i < 10; i++) begin
      if (ce_a) n_ce++;
      if (i < 4) begin
        chk("bp_addr", addr_a, 32'(4 * i));
      end else begin
        chk("bp_full_ce", 32'(ce_a), 32'h0);
        chk("bp_hold_pc", pc_a, 32'h0);
      end
      cyc();
    end
    chk("bp_ce_cycles", 32'(n_ce), 32'd4);
    rdy_a = 1'b1; #1;
    chk("drain_full_ce", 32'(ce_a), 32'h0);
    chk("drain_pc0", pc_a, 32'h0);
    for (int j = 1; j < 5; j++) begin
      cyc();
      if (j == 1) chk("drain_resume_addr", addr_a, 32'h10);
      chk("drain_vld", 32'(vld_a), 32'h1);
      chk("drain_pc", pc_a, 32'(4 * j));
    end

    // Redirect with three queued entries
    rst_a = 1'b1; cyc();
    rst_a = 1'b0; rdy_a = 1'b0; #1;
    cyc(); cyc(); cyc();
    br_a = 1'b1; tgt_a = 32'h0000_0103; #1;
    chk("br_vld", 32'(vld_a), 32'h0);
    chk("br_ce", 32'(ce_a), 32'h0);
    chk("br_pc", pc_a, 32'h0);
    cyc();
    br_a = 1'b0; rdy_a = 1'b1; #1;
    chk("br_tgt_ce", 32'(ce_a), 32'h1);
    chk("br_tgt_addr", addr_a, 32'h100);
    chk("br_tgt_vld0", 32'(vld_a), 32'h0);
    cyc();
    chk("br_issue_vld", 32'(vld_a), 32'h1);
    chk("br_issue_pc", pc_a, 32'h100);
    chk("br_issue_inst", inst_a, 32'hA5A5_0100);
    cyc();
    chk("br_next_pc", pc_a, 32'h104);

    // Reset beats redirect while full
    rst_a = 1'b1; cyc();
    rst_a = 1'b0; rdy_a = 1'b0; #1;
    repeat (5) cyc();
    chk("full_ce", 32'(ce_a), 32'h0);
    chk("full_vld", 32'(vld_a), 32'h1);
    rst_a = 1'b1; br_a = 1'b1; tgt_a = 32'h0000_0200; #1;
    chk("rb_ce", 32'(ce_a), 32'h0);
    cyc();
    br_a = 1'b0; #1;
    chk("rb_ce0", 32'(ce_a), 32'h0);
    chk("rb_addr0", addr_a, 32'h0);
    chk("rb_vld0", 32'(vld_a), 32'h0);
    chk("rb_pc0", pc_a, 32'h0);
    chk("rb_inst0", inst_a, 32'h0);
    rst_a = 1'b0; #1;
    chk("rb_restart_ce", 32'(ce_a), 32'h1);
    chk("rb_restart_addr", addr_a, 32'h0);
    cyc();
    chk("rb_restart_pc", pc_a, 32'h0);

    // PC wrap from the top of the address space
    cyc();
    rst_b = 1'b0; rdy_b = 1'b1; #1;
    chk("wrap_addr0", addr_b, 32'hFFFF_FFF8);
    exp_b[0] = 32'hFFFF_FFF8;
    exp_b[1] = 32'hFFFF_FFFC;
    exp_b[2] = 32'h0000_0000;
    exp_b[3] = 32'h0000_0004;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("wrap_pc", pc_b, exp_b[k]);
      chk("wrap_inst", inst_b, exp_b[k] ^ 32'hA5A5_0000);
    end

`ifdef IF_FETCH_PERF_EN
    // Performance counters
    rst_a = 1'b1; cyc();
    chk("perf_rst_fetch", pf_a, 32'h0);
    chk("perf_rst_flush", pl_a, 32'h0);
    rst_a = 1'b0; rdy_a = 1'b1; #1;
    repeat (7) cyc();
    rdy_a = 1'b0; #1;
    cyc();
    chk("perf_fetch8", pf_a, 32'd8);
    br_a = 1'b1; tgt_a = 32'h40; #1;
    cyc(); cyc();
    br_a = 1'b0; #1;
    chk("perf_fetch", pf_a, 32'd8);
    chk("perf_flush", pl_a, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch initiator for the OpenMIPS core: owns the program counter, drives the chip-enable and byte address of the combinational instruction ROM, and captures returned words into a small prefetch queue that feeds the decode stage over a valid/ready handshake. Sits between the instruction ROM and ID; branch redirects from ID flush the queue and restart fetch at the target.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `FIFO_DEPTH`, default 4: prefetch queue entries. Power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rom_ce_o` out 1: ROM chip enable; 1 = fetch this cycle.
- `rom_addr_o` out 32: ROM byte address; word-aligned; 0 when `rom_ce_o`=0.
- `rom_inst_i` in 32: ROM data. Combinational response to `rom_addr_o` in the same cycle.
- `branch_flag_i` in 1: redirect request from ID, one-cycle pulse.
- `branch_target_i` in 32: redirect address; bits [1:0] ignored and treated as 0.
- `id_ready_i` in 1: ID accepts the head entry this cycle.
- `id_valid_o` out 1: head entry valid.
- `id_pc_o` out 32: PC of the head entry; 0 when `id_valid_o`=0.
- `id_inst_o` out 32: instruction of the head entry; 0 when `id_valid_o`=0.

## Operation

- State: `pc` (32), circular queue of {pc, inst} with `FIFO_DEPTH` entries, read pointer, write pointer, and `count` (log2(DEPTH)+1 bits).
- Fetch enable: `fetch = !rst && !branch_flag_i && (count < FIFO_DEPTH)`. `rom_ce_o = fetch`. `rom_addr_o = fetch ? pc : 0`.
- Push: on an edge with `fetch`=1, write {pc, `rom_inst_i`} at the write pointer, then set `pc <= pc + 4`. 32-bit wrap: 32'hFFFF_FFFC → 32'h0000_0000.
- Pop: `id_valid_o = (count != 0) && !branch_flag_i`. On an edge where `id_valid_o && id_ready_i`, advance the read pointer.
- Push and pop on the same edge leave `count` unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Full (`count`=DEPTH): no fetch that cycle. A pop on that edge lowers `count`, and fetch resumes the next cycle. Throughput stays 1 instruction per cycle because the queue is non-empty.
- Empty: `id_valid_o`=0, `id_pc_o`=`id_inst_o`=0.
- Redirect: an edge with `branch_flag_i`=1 sets pointers and `count` to 0 and `pc <= {branch_target_i[31:2],2'b00}`. No push and no pop occur on that edge, and `id_valid_o`=0 in that cycle. Redirect wins over push, pop and full.
- Reset: pointers, `count`=0, `pc`=`RESET_PC`. Reset wins over redirect. Reset mid-stream discards all queued entries.

## Timing

- Reset values: `rom_ce_o`=0, `rom_addr_o`=0, `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0.
- First cycle after `rst` falls: `rom_ce_o`=1, `rom_addr_o`=`RESET_PC`.
- Fetch-to-issue latency is 1 cycle. A word fetched in cycle N appears at the queue head no earlier than cycle N+1 (N+1 exactly if the queue was empty).
- Redirect in cycle N: fetch of the target in N+1, target instruction valid at ID in N+2.
- `id_*` outputs are combinational from queue state plus `branch_flag_i`. There is no combinational path from `id_ready_i` to any output.

## Configuration

- `IF_FETCH_PERF_EN` defined: adds `perf_fetch_o` out 32 and `perf_flush_o` out 32.
  - `perf_fetch_o` increments on every push edge.
  - `perf_flush_o` increments on every redirect edge that discards `count`>0 entries.
  - Both reset to 0 and wrap at 2^32.
- `IF_FETCH_PERF_EN` undefined: ports and counters are absent. Behaviour is otherwise identical.

## Test plan

- Reset, then `id_ready_i`=1, ROM returns `addr^32'hA5A5_0000`. Expect `rom_addr_o` 0,4,8,… from cycle 1; `id_valid_o`=1 from cycle 2 with `id_pc_o` 0,4,8,… and matching `id_inst_o`; 1 instruction/cycle.
- `id_ready_i`=0 for 10 cycles after reset. Expect `rom_ce_o` high for exactly 4 cycles (addresses 0..C), then low with `count`=4. Raising `id_ready_i` drains 0,4,8,C with no gap, then 0x10 follows.
- Queue holding 3 entries, pulse `branch_flag_i` with target 32'h0000_0103. Expect `id_valid_o`=0 and `rom_ce_o`=0 that cycle, `rom_addr_o`=0x100 next cycle, and `id_pc_o`=0x100 the cycle after; stale entries never issued.
- `RESET_PC`=32'hFFFF_FFF8, `id_ready_i`=1. Expect issued PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `rst` while the queue is full and `branch_flag_i`=1 in the same cycle. Expect all outputs 0 next cycle and fetch restarting at `RESET_PC`, not at the branch target.
- With `IF_FETCH_PERF_EN`: 8 pushes, then one redirect with 2 queued entries, then one redirect with an empty queue. Expect `perf_fetch_o`=8 and `perf_flush_o`=1.
